// File: rtl/noise_hist_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : noise_hist_reader_if
//  Description : Control, noise-sample input and histogram byte-stream
//                signals of the noise histogram reader.
//  Revision    : 1.0  initial release
// ============================================================================
interface noise_hist_reader_if;
  logic        start;
  logic [7:0]  noise_in;
  logic        noise_in_valid;
  logic [7:0]  dump_byte;
  logic        dump_valid;
  logic        dump_ready;
  logic        busy;
  logic        done;
  logic [15:0] oor_cnt;

  // Driver side: issues control and samples, accepts dump bytes
  modport master (
    output start, noise_in, noise_in_valid, dump_ready,
    input  dump_byte, dump_valid, busy, done, oor_cnt
  );

  // Histogram reader side
  modport slave (
    input  start, noise_in, noise_in_valid, dump_ready,
    output dump_byte, dump_valid, busy, done, oor_cnt
  );
endinterface
`default_nettype wire

// File: rtl/noise_hist_reader.sv
`default_nettype none
// ============================================================================
//  Module      : noise_hist_reader
//  Description : Bins a window of signed noise samples into a histogram, then
//                streams a header byte and every bin (MSB first) out over a
//                valid/ready byte handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module noise_hist_reader #(
  parameter int          NBINS  = 128,
  parameter int          OFFSET = 63,
  parameter int          CNT_W  = 16,
  parameter int          WINDOW = 4096,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rstn,
  noise_hist_reader_if.slave   bus
);

  localparam int c_bin_w  = $clog2(NBINS);
  localparam int c_bidx_w = $clog2(2*NBINS+1);
  localparam int c_scnt_w = $clog2(WINDOW+1);

  localparam logic [c_bidx_w-1:0] c_last_byte = c_bidx_w'(2*NBINS);
  localparam logic [c_scnt_w-1:0] c_win_last  = c_scnt_w'(WINDOW-1);
  localparam logic signed [8:0]   c_offset    = 9'(OFFSET);
  localparam logic signed [8:0]   c_nbins     = 9'(NBINS);
  localparam logic [CNT_W-1:0]    c_bin_max   = {CNT_W{1'b1}};

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_clear = 2'd1;
  localparam logic [1:0] c_accum = 2'd2;
  localparam logic [1:0] c_dump  = 2'd3;

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [CNT_W-1:0]    r_bin [NBINS];
  logic [c_scnt_w-1:0] r_sample_cnt;
  logic [15:0]         r_oor_cnt;
  logic [c_bidx_w-1:0] r_byte_idx;
  logic                r_done;

  logic                w_sample;
  logic signed [8:0]   w_idx;
  logic                w_in_range;
  logic [c_bin_w-1:0]  w_bin_sel;
  logic                w_accept;
  logic                w_last;
  logic [c_bidx_w-1:0] w_byte_m1;
  logic [c_bin_w-1:0]  w_rd_bin;
  logic                w_rd_hi;
  logic [15:0]         w_bin16;
  logic [7:0]          w_dump_byte;
  logic                w_dump_valid;
  logic                w_busy;

  // Bin index is formed in 9-bit signed so the full 8-bit sample range plus
  // offset never wraps; anything negative or past the last bin is out of range.
  assign w_sample   = (r_state == c_accum) && bus.noise_in_valid;
  assign w_idx      = $signed({bus.noise_in[7], bus.noise_in}) + c_offset;
  assign w_in_range = !w_idx[8] && (w_idx < c_nbins);
  assign w_bin_sel  = w_idx[c_bin_w-1:0];

  // Byte 0 is the header; byte k>0 carries bin (k-1)/2, even offsets high half.
  assign w_accept  = (r_state == c_dump) && bus.dump_ready;
  assign w_last    = (r_byte_idx == c_last_byte);
  assign w_byte_m1 = r_byte_idx - c_bidx_w'(1);
  assign w_rd_bin  = c_bin_w'(w_byte_m1 >> 1);
  assign w_rd_hi   = ~w_byte_m1[0];
  assign w_bin16   = 16'(r_bin[w_rd_bin]);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_idle;
    else       r_state <= w_next;
  end

  // Next-state logic: window completes on the sample that fills it
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (bus.start) w_next = c_clear;
      c_clear: w_next = c_accum;
      c_accum: if (w_sample && (r_sample_cnt == c_win_last)) w_next = c_dump;
      c_dump:  if (w_accept && w_last) w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Outputs decoded from state; bins are frozen in DUMP so the byte is stable
  always_comb begin
    w_busy       = (r_state != c_idle);
    w_dump_valid = (r_state == c_dump);
    w_dump_byte  = 8'h00;
    if (r_state == c_dump) begin
      if (r_byte_idx == '0) w_dump_byte = HDR;
      else if (w_rd_hi)     w_dump_byte = w_bin16[15:8];
      else                  w_dump_byte = w_bin16[7:0];
    end
  end

  // Histogram bins: cleared per run, saturating increment on in-range samples
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NBINS; i++) r_bin[i] <= '0;
    end else if (r_state == c_clear) begin
      for (int i = 0; i < NBINS; i++) r_bin[i] <= '0;
    end else if (w_sample && w_in_range && (r_bin[w_bin_sel] != c_bin_max)) begin
      r_bin[w_bin_sel] <= r_bin[w_bin_sel] + CNT_W'(1);
    end
  end

  // Window sample counter and saturating out-of-range counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sample_cnt <= '0;
      r_oor_cnt    <= '0;
    end else if (r_state == c_clear) begin
      r_sample_cnt <= '0;
      r_oor_cnt    <= '0;
    end else if (w_sample) begin
      r_sample_cnt <= r_sample_cnt + c_scnt_w'(1);
      if (!w_in_range && (r_oor_cnt != 16'hFFFF)) r_oor_cnt <= r_oor_cnt + 16'd1;
    end
  end

  // Dump byte pointer and the done pulse following the final accepted byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_byte_idx <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_accept && w_last;
      if (r_state == c_clear)  r_byte_idx <= '0;
      else if (w_accept)       r_byte_idx <= w_last ? '0 : r_byte_idx + c_bidx_w'(1);
    end
  end

  assign bus.dump_byte  = w_dump_byte;
  assign bus.dump_valid = w_dump_valid;
  assign bus.busy       = w_busy;
  assign bus.done       = r_done;
  assign bus.oor_cnt    = r_oor_cnt;

endmodule
`default_nettype wire

// File: tb/tb_noise_hist_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noise_hist_reader
//  Description : Directed bench for noise_hist_reader. Unit A runs an 8-sample
//                window with 16-bit bins, unit B a 20-sample window with 4-bit
//                bins to exercise saturation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_noise_hist_reader;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  noise_hist_reader_if ifa ();
  noise_hist_reader_if ifb ();

  noise_hist_reader #(.NBINS(128), .OFFSET(63), .CNT_W(16), .WINDOW(8), .HDR(8'hA5))
    u_dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));

  noise_hist_reader #(.NBINS(128), .OFFSET(63), .CNT_W(4), .WINDOW(20), .HDR(8'hA5))
    u_dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got [0:256];
  int         ngot;
  int         exp_bin [128];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pulse_start(input int which);
    if (which != 0) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // start, then wait out CLEAR so the unit is in ACCUM on return
  task automatic begin_run(input int which);
    pulse_start(which);
    @(negedge clk);
    check_val("busy_accum", (which != 0) ? ifb.busy : ifa.busy, 1);
  endtask

  task automatic send(input int which, input int v);
    logic [7:0] b;
    b = v[7:0];
    if (which != 0) begin ifb.noise_in = b; ifb.noise_in_valid = 1'b1; end
    else            begin ifa.noise_in = b; ifa.noise_in_valid = 1'b1; end
    @(negedge clk);
    ifa.noise_in_valid = 1'b0;
    ifb.noise_in_valid = 1'b0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) exp_bin[i] = 0;
  endtask

  // Accept nbytes bytes; rnd toggles ready randomly and checks held bytes
  task automatic dump(input int which, input int nbytes, input bit rnd);
    int         cyc;
    logic       pv, v, r;
    logic [7:0] pb, b;
    ngot = 0; pv = 1'b0; pb = 8'h00; cyc = 0;
    while (ngot < nbytes && cyc < 3000) begin
      v = (which != 0) ? ifb.dump_valid : ifa.dump_valid;
      b = (which != 0) ? ifb.dump_byte  : ifa.dump_byte;
      if (pv) begin
        check_val("hold_valid", v, 1);
        check_val("hold_byte", b, pb);
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (which != 0) ifb.dump_ready = r; else ifa.dump_ready = r;
      if (v && r) begin
        got[ngot] = b;
        ngot++;
      end
      pv = v && !r;
      pb = b;
      @(negedge clk);
      cyc++;
    end
    ifa.dump_ready = 1'b0;
    ifb.dump_ready = 1'b0;
    if (ngot < nbytes) check_val("dump_timeout", ngot, nbytes);
  endtask

  task automatic finish_check(input int which);
    check_val("done_pulse", (which != 0) ? ifb.done : ifa.done, 1);
    check_val("busy_at_done", (which != 0) ? ifb.busy : ifa.busy, 0);
    @(negedge clk);
    check_val("done_single", (which != 0) ? ifb.done : ifa.done, 0);
    check_val("valid_after", (which != 0) ? ifb.dump_valid : ifa.dump_valid, 0);
  endtask

  task automatic check_dump();
    logic [15:0] bv;
    logic [7:0]  e;
    for (int k = 0; k < 257; k++) begin
      if (k == 0) e = 8'hA5;
      else begin
        bv = 16'(exp_bin[(k-1)/2]);
        e  = ((k-1) % 2 == 0) ? bv[15:8] : bv[7:0];
      end
      check_val($sformatf("byte%0d", k), got[k], e);
    end
  endtask

  initial begin
    rstn = 1'b0;
    ifa.start = 1'b0; ifa.noise_in = 8'h00; ifa.noise_in_valid = 1'b0; ifa.dump_ready = 1'b0;
    ifb.start = 1'b0; ifb.noise_in = 8'h00; ifb.noise_in_valid = 1'b0; ifb.dump_ready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    check_val("rst_valid", ifa.dump_valid, 0);
    check_val("rst_busy",  ifa.busy, 0);
    check_val("rst_done",  ifa.done, 0);
    check_val("rst_oor",   ifa.oor_cnt, 0);
    check_val("rst_byte",  ifa.dump_byte, 0);
    rstn = 1'b1;
    @(negedge clk);

    // eight zero samples land in bin 63
    begin_run(0);
    repeat (8) send(0, 0);
    check_val("t2_oor", ifa.oor_cnt, 0);
    clear_exp();
    exp_bin[63] = 8;
    dump(0, 257, 1'b0);
    finish_check(0);
    check_dump();

    // range edges, then random backpressure during the dump
    begin_run(0);
    send(0, -63); send(0, 64); send(0, -64); send(0, 65); send(0, -128); send(0, 127);
    check_val("t3_oor6", ifa.oor_cnt, 4);
    check_val("t3_busy", ifa.busy, 1);
    send(0, 0); send(0, 0);
    check_val("t3_oor8", ifa.oor_cnt, 4);
    clear_exp();
    exp_bin[0] = 1; exp_bin[127] = 1; exp_bin[63] = 2;
    dump(0, 257, 1'b1);
    finish_check(0);
    check_dump();
    repeat (3) @(negedge clk);
    check_val("t3_oor_kept", ifa.oor_cnt, 4);

    // start during ACCUM and samples/start during DUMP are ignored
    begin_run(0);
    repeat (3) send(0, 1);
    pulse_start(0);
    repeat (5) send(0, 1);
    check_val("t6_in_dump", ifa.dump_valid, 1);
    repeat (3) send(0, -63);
    pulse_start(0);
    check_val("t6_oor", ifa.oor_cnt, 0);
    check_val("t6_hdr", ifa.dump_byte, 8'hA5);
    clear_exp();
    exp_bin[64] = 8;
    dump(0, 257, 1'b0);
    finish_check(0);
    check_dump();

    // 4-bit bins saturate at 0xF rather than wrapping
    begin_run(1);
    repeat (20) send(1, 5);
    clear_exp();
    exp_bin[68] = 15;
    dump(1, 257, 1'b0);
    finish_check(1);
    check_val("t4_bin68_hi", got[137], 8'h00);
    check_val("t4_bin68_lo", got[138], 8'h0F);
    check_dump();

    // reset in the middle of a dump abandons the run
    begin_run(0);
    repeat (8) send(0, 100);
    check_val("t1_oor_pre", ifa.oor_cnt, 8);
    dump(0, 40, 1'b0);
    check_val("t1_mid_valid", ifa.dump_valid, 1);
    rstn = 1'b0;
    #1;
    check_val("t1_rst_valid", ifa.dump_valid, 0);
    check_val("t1_rst_busy",  ifa.busy, 0);
    check_val("t1_rst_oor",   ifa.oor_cnt, 0);
    check_val("t1_rst_done",  ifa.done, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check_val("t1_no_done", ifa.done, 0);
    begin_run(0);
    repeat (8) send(0, -1);
    clear_exp();
    exp_bin[62] = 8;
    dump(0, 257, 1'b0);
    finish_check(0);
    check_dump();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
